// File: rtl/onewire_pkg.sv
// onewire_pkg: shared 1-Wire slave types, timing conversion and CRC8 step.
// Contents: state enum, us-to-cycle conversion, reflected CRC8 polynomial.
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PD_WAIT,
    PD_DRIVE,
    SLOT_WAIT,
    SLOT_RUN,
    SLOT_END
  } ow_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h8C;

  function automatic logic [23:0] us2cyc(
    input int us,
    input int mhz
  );
    return 24'(us * mhz);
  endfunction

  // Dallas/Maxim CRC8, one LSB-first serial bit.
  function automatic logic [7:0] crc8_step(
    input logic [7:0] c,
    input logic       b
  );
    logic [7:0] s;
    s = c >> 1;
    if (c[0] ^ b) s = s ^ CRC8_POLY;
    return s;
  endfunction

endpackage

// File: rtl/onewire_sync_edge.sv
// onewire_sync_edge: 2-flop synchroniser with rise/fall pulses (2-cycle latency).
// Ports: clk_i, rst_i (sync, high), d_i async in; level_o, rise_o, fall_o.
module onewire_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~prev_q;
  assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/onewire_slave.sv
// onewire_slave: 1-Wire standard-speed responder (reset/presence, byte rx/tx).
// Ports: clk, rst, ow_in, ow_pull, tx_*, rx_*, bus_reset, busy, crc_out
// (crc_out live only with ONEWIRE_SLAVE_CRC8_EN defined, else tied 0).
module onewire_slave #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int T_RST_DET    = 480,
  parameter int T_PDH        = 15,
  parameter int T_PDL        = 60,
  parameter int T_SAMPLE     = 30,
  parameter int T_RD0        = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ow_in,
  output logic       ow_pull,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       bus_reset,
  output logic       busy,
  output logic [7:0] crc_out
);
  import onewire_pkg::*;

  localparam logic [23:0] RST_CYC = us2cyc(T_RST_DET, CLK_FREQ_MHZ);
  localparam logic [23:0] PDH_CYC = us2cyc(T_PDH, CLK_FREQ_MHZ);
  localparam logic [23:0] PDL_CYC = us2cyc(T_PDL, CLK_FREQ_MHZ);
  localparam logic [23:0] SMP_CYC = us2cyc(T_SAMPLE, CLK_FREQ_MHZ);
  localparam logic [23:0] RD0_CYC = us2cyc(T_RD0, CLK_FREQ_MHZ);
  localparam logic [23:0] END_CYC =
    (SMP_CYC > RD0_CYC) ? SMP_CYC : RD0_CYC;
  localparam logic [23:0] CNT_MAX = '1;

  logic line;
  logic rise;
  logic fall;

  onewire_sync_edge u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (ow_in),
    .level_o(line),
    .rise_o (rise),
    .fall_o (fall)
  );

  ow_state_e   state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] low_q, low_d;
  logic        seen_q, seen_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        bus_reset_q, bus_reset_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_pend_q, tx_pend_d;
  logic        tx_hold_q, tx_hold_d;

  logic pull;
  logic sample;
  logic low_now;
  logic abort;

  // tx_hold marks a byte loaded on this slot's edge; it starts next slot.
  assign pull = (state_q == PD_DRIVE) |
                ((state_q == SLOT_RUN) & tx_pend_q & ~tx_hold_q &
                 ~tx_sh_q[idx_q] & (cnt_q < RD0_CYC));
  assign sample  = (state_q == SLOT_RUN) && (cnt_q == SMP_CYC - 24'd1);
  assign low_now = ~line & ~pull;
  assign abort   = low_now && (low_q >= RST_CYC - 24'd1);

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    idx_d       = idx_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    bus_reset_d = 1'b0;
    tx_sh_d     = tx_sh_q;
    tx_pend_d   = tx_pend_q;
    tx_hold_d   = tx_hold_q;

    unique case (state_q)
      IDLE: ;
      PD_WAIT:
        if (cnt_q == PDH_CYC - 24'd1) state_d = PD_DRIVE;
      PD_DRIVE:
        if (cnt_q == PDL_CYC - 24'd1) state_d = SLOT_WAIT;
      SLOT_WAIT:
        if (fall) state_d = SLOT_RUN;
      SLOT_RUN:
        if (cnt_q == END_CYC - 24'd1) state_d = SLOT_END;
      SLOT_END:
        if (line) state_d = SLOT_WAIT;
      default: state_d = IDLE;
    endcase

    if (tx_load && !tx_pend_q &&
        (state_q == SLOT_WAIT || state_q == IDLE)) begin
      tx_sh_d   = tx_data;
      tx_pend_d = 1'b1;
      tx_hold_d = fall && (state_q == SLOT_WAIT);
    end

    if (sample) begin
      rx_sh_d[idx_q] = line;
      idx_d          = idx_q + 3'd1;
      tx_hold_d      = 1'b0;
      if (idx_q == 3'd7) begin
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
        tx_pend_d  = tx_pend_q & tx_hold_q;
      end
    end

    if (abort) begin
      seen_d     = 1'b1;
      state_d    = IDLE;
      idx_d      = 3'd0;
      rx_sh_d    = 8'h00;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_pend_d  = 1'b0;
      tx_hold_d  = 1'b0;
    end

    if (seen_q && rise) begin
      seen_d      = 1'b0;
      bus_reset_d = 1'b1;
      state_d     = PD_WAIT;
    end

    cnt_d = (state_d != state_q) ? 24'd0 :
            (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 24'd1;
    low_d = !low_now ? 24'd0 :
            (low_q == CNT_MAX) ? low_q : low_q + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      low_q       <= '0;
      seen_q      <= 1'b0;
      idx_q       <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bus_reset_q <= 1'b0;
      tx_sh_q     <= '0;
      tx_pend_q   <= 1'b0;
      tx_hold_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      low_q       <= low_d;
      seen_q      <= seen_d;
      idx_q       <= idx_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      bus_reset_q <= bus_reset_d;
      tx_sh_q     <= tx_sh_d;
      tx_pend_q   <= tx_pend_d;
      tx_hold_q   <= tx_hold_d;
    end
  end

`ifdef ONEWIRE_SLAVE_CRC8_EN
  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (bus_reset_d) crc_d = 8'h00;
    else if (sample && !abort) crc_d = crc8_step(crc_q, line);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 8'h00;
    else     crc_q <= crc_d;
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 8'h00;
`endif

  assign ow_pull   = pull;
  assign tx_ready  = ~tx_pend_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign bus_reset = bus_reset_q;
  assign busy      = (state_q != IDLE) && (state_q != SLOT_WAIT);

endmodule

// File: tb/tb_onewire_slave.sv
// tb_onewire_slave: directed bench for onewire_slave with an open-drain bus
// model; the slave runs at a reduced clock rate so all timings stay short.
module tb_onewire_slave;

  localparam int MHZ = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_low = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ow_pull;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       bus_reset;
  logic       busy;
  logic [7:0] crc_out;
  wire        ow_bus = ~(m_low | ow_pull);

  int checks = 0;
  int failures = 0;
  int rxv_cnt = 0;
  int br_cnt = 0;
  int pull_cyc = 0;
  int pull_mark;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rd;
  logic       b;

  always #10 clk = ~clk;

  onewire_slave #(.CLK_FREQ_MHZ(MHZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .ow_in    (ow_bus),
    .ow_pull  (ow_pull),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .bus_reset(bus_reset),
    .busy     (busy),
    .crc_out  (crc_out)
  );

  always @(posedge clk) begin
    if (rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_last <= rx_data;
    end
    if (bus_reset) br_cnt <= br_cnt + 1;
    if (ow_pull) pull_cyc <= pull_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic low_for(input int n);
    m_low = 1'b1;
    cyc(n);
    m_low = 1'b0;
  endtask

  task automatic bus_rst();
    low_for(480 * MHZ);
    cyc(90 * MHZ);
  endtask

  task automatic wr_bit(input logic v);
    if (v) begin
      low_for(6 * MHZ);
      cyc(29 * MHZ);
    end else begin
      low_for(60 * MHZ);
      cyc(3 * MHZ);
    end
  endtask

  task automatic wr_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) wr_bit(v[i]);
  endtask

  task automatic rd_bit(output logic v);
    low_for(MHZ);
    cyc(14 * MHZ);
    v = ow_bus;
    cyc(20 * MHZ);
  endtask

  initial begin
    cyc(3);
    chk("rst_pull", ow_pull, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_bus_reset", bus_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_crc", crc_out, 0);
    rst = 1'b0;
    cyc(5);

    low_for(460 * MHZ);
    cyc(1000);
    chk("short_low_no_reset", br_cnt, 0);
    chk("short_low_no_pull", pull_cyc, 0);

    pull_mark = pull_cyc;
    low_for(480 * MHZ);
    cyc(140);
    chk("pd_before", ow_pull, 0);
    cyc(20);
    chk("pd_start", ow_pull, 1);
    chk("pd_busy", busy, 1);
    cyc(580);
    chk("pd_hold", ow_pull, 1);
    cyc(20);
    chk("pd_end", ow_pull, 0);
    chk("pd_len", pull_cyc - pull_mark, 60 * MHZ);
    chk("bus_reset_once", br_cnt, 1);
    chk("idle_busy", busy, 0);
    cyc(50);

    wr_byte(8'hA5);
    cyc(5);
    chk("rx_a5_cnt", rxv_cnt, 1);
    chk("rx_a5_pulse", rx_last, 8'hA5);
    chk("rx_a5_data", rx_data, 8'hA5);
`ifndef ONEWIRE_SLAVE_CRC8_EN
    chk("crc_tied0", crc_out, 0);
`endif

    chk("tx_ready_pre", tx_ready, 1);
    tx_data = 8'h3C;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    chk("tx_ready_loaded", tx_ready, 0);
    for (int i = 0; i < 8; i++) begin
      rd_bit(b);
      rd[i] = b;
    end
    cyc(5);
    chk("read_3c", rd, 8'h3C);
    chk("tx_ready_done", tx_ready, 1);
    chk("read_echo_cnt", rxv_cnt, 2);
    chk("read_echo_data", rx_data, 8'h3C);

    tx_data = 8'hFF;
    tx_load = 1'b1;
    cyc(1);
    tx_load = 1'b0;
    wr_bit(1'b1);
    wr_bit(1'b0);
    wr_bit(1'b1);
    chk("mid_tx_pending", tx_ready, 0);
    low_for(480 * MHZ);
    cyc(2);
    chk("mid_tx_dropped", tx_ready, 1);
    cyc(90 * MHZ);
    chk("mid_bus_reset", br_cnt, 2);
    chk("mid_no_rx_valid", rxv_cnt, 2);
    wr_byte(8'h5A);
    cyc(5);
    chk("mid_next_cnt", rxv_cnt, 3);
    chk("mid_next_data", rx_data, 8'h5A);

`ifdef ONEWIRE_SLAVE_CRC8_EN
    bus_rst();
    chk("crc_cleared", crc_out, 0);
    wr_byte(8'h02);
    cyc(5);
    chk("crc_after_02", crc_out, 8'hBC);
    wr_byte(8'h1C);
    wr_byte(8'hB8);
    wr_byte(8'h01);
    wr_byte(8'h00);
    wr_byte(8'h00);
    wr_byte(8'h00);
    wr_byte(8'hA2);
    cyc(5);
    chk("crc_rom_zero", crc_out, 0);
    chk("crc_rom_last", rx_data, 8'hA2);
    chk("crc_rom_cnt", rxv_cnt, 11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
